// File: rtl/write_stage.sv
// write_stage -- write-back stage of the 16-bit pipelined processor.
//
// Picks the register-file write data from the ALU result, the memory load
// data or the link address (PC+2). It registers that data together with the
// destination register number and the write enable. The registered outputs
// drive the register-file write port directly.
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        asynchronous, active-high; clears all outputs immediately
//   RegWrite     write enable of the instruction in write-back
//   RegStore     source select: 00 mem, 01 ALU, 10 PC+2, 11 reserved (zero)
//   IPCP2        incremented PC, used as the link/return address
//   ALUResult    pipelined ALU result
//   StoreMem     data read from data memory
//   rdWB         destination register number
//   loadData     registered write-back data
//   loadAddr     registered destination register number
//   regWriteOut  registered write enable; qualifies loadData/loadAddr
module write_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic [1:0]  RegStore,
  input  logic [15:0] IPCP2,
  input  logic [15:0] ALUResult,
  input  logic [15:0] StoreMem,
  input  logic [2:0]  rdWB,
  output logic [15:0] loadData,
  output logic [2:0]  loadAddr,
  output logic        regWriteOut
);

  typedef enum logic [1:0] {
    SRC_MEM  = 2'b00,
    SRC_ALU  = 2'b01,
    SRC_PC   = 2'b10,
    SRC_RSVD = 2'b11
  } src_e;

  src_e        src_sel;
  logic [15:0] data_d;
  logic [15:0] data_q;
  logic [2:0]  addr_q;
  logic        we_q;

  assign src_sel = src_e'(RegStore);

  // The reserved encoding yields zero, so a stray select never writes
  // stale or undefined data into the register file.
  always_comb begin
    data_d = '0;
    unique case (src_sel)
      SRC_MEM:  data_d = StoreMem;
      SRC_ALU:  data_d = ALUResult;
      SRC_PC:   data_d = IPCP2;
      SRC_RSVD: data_d = '0;
      default:  data_d = '0;
    endcase
  end

  // Address and data load every cycle, whatever the state of RegWrite.
  // Consumers qualify them with regWriteOut.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      addr_q <= rdWB;
      we_q   <= RegWrite;
    end
  end

  assign loadData    = data_q;
  assign loadAddr    = addr_q;
  assign regWriteOut = we_q;

endmodule

// File: tb/tb_write_stage.sv
// tb_write_stage -- self-checking bench for write_stage.
//
// Before each rising edge the bench computes the expected register contents
// from its own source-select model and pushes them to a scoreboard queue.
// After the edge it pops them and compares them with the DUT outputs.
// The asynchronous-reset checks compare against fixed zero values between
// edges.
module tb_write_stage;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [1:0]  RegStore;
  logic [15:0] IPCP2;
  logic [15:0] ALUResult;
  logic [15:0] StoreMem;
  logic [2:0]  rdWB;
  logic [15:0] loadData;
  logic [2:0]  loadAddr;
  logic        regWriteOut;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  a;
    logic        w;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  write_stage dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .RegStore   (RegStore),
    .IPCP2      (IPCP2),
    .ALUResult  (ALUResult),
    .StoreMem   (StoreMem),
    .rdWB       (rdWB),
    .loadData   (loadData),
    .loadAddr   (loadAddr),
    .regWriteOut(regWriteOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source selection as the processor defines it. This model is independent
  // of the DUT.
  function automatic logic [15:0] model_data(input logic [1:0] sel,
                                             input logic [15:0] mem,
                                             input logic [15:0] alu,
                                             input logic [15:0] pc);
    case (sel)
      2'b00:   return mem;
      2'b01:   return alu;
      2'b10:   return pc;
      default: return 16'h0000;
    endcase
  endfunction

  // Push the expected result for the current inputs, then step one rising
  // edge. Sampling happens 1 time unit after the edge.
  task automatic apply_edge();
    exp_t e;
    if (reset) begin
      e = '0;
    end else begin
      e.d = model_data(RegStore, StoreMem, ALUResult, IPCP2);
      e.a = rdWB;
      e.w = RegWrite;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: size=0 required>0");
      e = '0;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic set_scenario1_inputs();
    RegWrite  = 1'b1;
    RegStore  = 2'b01;
    ALUResult = 16'hAAAA;
    StoreMem  = 16'hBBBB;
    IPCP2     = 16'hCCCC;
    rdWB      = 3'b101;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    set_scenario1_inputs();
    #1;
    n_vec++;
    if ({loadData, loadAddr, regWriteOut} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_async_initial: got=%h/%b/%b required=0000/000/0",
               loadData, loadAddr, regWriteOut);
    end
    for (int unsigned i = 0; i < 2; i++) begin
      apply_edge();
      pop_exp(e);
      n_vec++;
      if (loadData !== e.d) begin
        n_err++;
        $display("FAIL reset_hold_data: got=%h required=%h", loadData, e.d);
      end
      n_vec++;
      if (loadAddr !== e.a) begin
        n_err++;
        $display("FAIL reset_hold_addr: got=%b required=%b", loadAddr, e.a);
      end
      n_vec++;
      if (regWriteOut !== e.w) begin
        n_err++;
        $display("FAIL reset_hold_we: got=%b required=%b", regWriteOut, e.w);
      end
    end
  endtask

  task automatic test_alu_wb();
    exp_t e;
    reset = 1'b0;
    apply_edge();
    pop_exp(e);
    n_vec++;
    if (loadData !== e.d || loadData !== 16'hAAAA) begin
      n_err++;
      $display("FAIL alu_wb_data: got=%h required=aaaa", loadData);
    end
    n_vec++;
    if (loadAddr !== e.a || loadAddr !== 3'b101) begin
      n_err++;
      $display("FAIL alu_wb_addr: got=%b required=101", loadAddr);
    end
    n_vec++;
    if (regWriteOut !== e.w || regWriteOut !== 1'b1) begin
      n_err++;
      $display("FAIL alu_wb_we: got=%b required=1", regWriteOut);
    end
  endtask

  task automatic test_source_sweep();
    exp_t e;
    logic [1:0]  sels [3];
    logic [15:0] req  [3];
    sels = '{2'b00, 2'b10, 2'b11};
    req  = '{16'hBBBB, 16'hCCCC, 16'h0000};
    for (int unsigned i = 0; i < 3; i++) begin
      RegStore = sels[i];
      apply_edge();
      pop_exp(e);
      n_vec++;
      if (loadData !== e.d || loadData !== req[i]) begin
        n_err++;
        $display("FAIL sweep_sel%b: got=%h required=%h", sels[i], loadData, req[i]);
      end
    end
  endtask

  task automatic test_write_disable();
    exp_t e;
    RegWrite = 1'b0;
    rdWB     = 3'b011;
    RegStore = 2'b01;
    apply_edge();
    pop_exp(e);
    n_vec++;
    if (regWriteOut !== e.w || regWriteOut !== 1'b0) begin
      n_err++;
      $display("FAIL wdis_we: got=%b required=0", regWriteOut);
    end
    n_vec++;
    if (loadAddr !== e.a || loadAddr !== 3'b011) begin
      n_err++;
      $display("FAIL wdis_addr: got=%b required=011", loadAddr);
    end
    n_vec++;
    if (loadData !== e.d || loadData !== 16'hAAAA) begin
      n_err++;
      $display("FAIL wdis_data: got=%h required=aaaa", loadData);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    RegWrite = 1'b1;
    rdWB     = 3'b110;
    apply_edge();
    pop_exp(e);
    n_vec++;
    if ({loadData, loadAddr, regWriteOut} !== {e.d, e.a, e.w}) begin
      n_err++;
      $display("FAIL areset_preload: got=%h/%b/%b required=%h/%b/%b",
               loadData, loadAddr, regWriteOut, e.d, e.a, e.w);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({loadData, loadAddr, regWriteOut} !== 20'h0) begin
      n_err++;
      $display("FAIL areset_midcycle: got=%h/%b/%b required=0000/000/0",
               loadData, loadAddr, regWriteOut);
    end
    #2;
    reset     = 1'b0;
    ALUResult = 16'h5A5A;
    rdWB      = 3'b001;
    apply_edge();
    pop_exp(e);
    n_vec++;
    if ({loadData, loadAddr, regWriteOut} !== {e.d, e.a, e.w}) begin
      n_err++;
      $display("FAIL areset_reload: got=%h/%b/%b required=%h/%b/%b",
               loadData, loadAddr, regWriteOut, e.d, e.a, e.w);
    end
  endtask

  task automatic test_input_change();
    exp_t e;
    ALUResult = 16'hAAAA;
    RegStore  = 2'b01;
    apply_edge();
    pop_exp(e);
    n_vec++;
    if (loadData !== e.d) begin
      n_err++;
      $display("FAIL ichg_load: got=%h required=%h", loadData, e.d);
    end
    #1;
    ALUResult = 16'h1234;
    #1;
    n_vec++;
    if (loadData !== 16'hAAAA) begin
      n_err++;
      $display("FAIL ichg_hold_high: got=%h required=aaaa", loadData);
    end
    @(negedge clk);
    #2;
    n_vec++;
    if (loadData !== 16'hAAAA) begin
      n_err++;
      $display("FAIL ichg_hold_low: got=%h required=aaaa", loadData);
    end
    apply_edge();
    pop_exp(e);
    n_vec++;
    if (loadData !== e.d || loadData !== 16'h1234) begin
      n_err++;
      $display("FAIL ichg_update: got=%h required=1234", loadData);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int unsigned i = 0; i < 24; i++) begin
      RegWrite  = 1'($urandom);
      RegStore  = 2'($urandom);
      IPCP2     = 16'($urandom);
      ALUResult = 16'($urandom);
      StoreMem  = 16'($urandom);
      rdWB      = 3'($urandom);
      apply_edge();
      pop_exp(e);
      n_vec++;
      if ({loadData, loadAddr, regWriteOut} !== {e.d, e.a, e.w}) begin
        n_err++;
        $display("FAIL b2b_%0d: got=%h/%b/%b required=%h/%b/%b", i,
                 loadData, loadAddr, regWriteOut, e.d, e.a, e.w);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_alu_wb();
    test_source_sweep();
    test_write_disable();
    test_async_reset();
    test_input_change();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
